// File: rtl/reg_file_pkg.sv
// Shared widths and types for the register file and its scoreboard.
// Default geometry is 32 x 32-bit; modules override via their own parameters.
package reg_file_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bundle: two read ports, the commit port and the issue port.
// Master is the pipeline side; slave is the register file.
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] RD1_ADDR;
    logic [ADDR_W-1:0] RD2_ADDR;
    logic [DATA_W-1:0] RD1_DATA;
    logic [DATA_W-1:0] RD2_DATA;
    logic              RD1_BUSY;
    logic              RD2_BUSY;
    logic              WR_EN;
    logic              WR_VALID;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              ISSUE_EN;
    logic [ADDR_W-1:0] ISSUE_ADDR;
    logic              ISSUE_READY;
    logic [ADDR_W:0]   PEND_CNT;

    modport master (
        output RD1_ADDR, RD2_ADDR, WR_EN, WR_VALID, WR_ADDR, WR_DATA, ISSUE_EN, ISSUE_ADDR,
        input  RD1_DATA, RD2_DATA, RD1_BUSY, RD2_BUSY, ISSUE_READY, PEND_CNT
    );

    modport slave (
        input  RD1_ADDR, RD2_ADDR, WR_EN, WR_VALID, WR_ADDR, WR_DATA, ISSUE_EN, ISSUE_ADDR,
        output RD1_DATA, RD2_DATA, RD1_BUSY, RD2_BUSY, ISSUE_READY, PEND_CNT
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits and pending count; busy/count update one edge after issue/commit.
// Issue to a busy register is refused (ISSUE_READY low) unless the same edge commits it.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_commit,
    input  logic [ADDR_W-1:0]       i_commit_addr,
    input  logic                    i_issue_en,
    input  logic [ADDR_W-1:0]       i_issue_addr,
    output logic [(1<<ADDR_W)-1:0]  o_busy,
    output logic                    o_issue_ready,
    output logic [ADDR_W:0]         o_pend_cnt
);
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [(1<<ADDR_W)-1:0] r_busy;
    logic [ADDR_W:0]        r_pend_cnt;
    logic                   w_same;
    logic                   w_issue_acc;
    logic                   w_set;
    logic                   w_clr;

    // A commit freeing the very register being issued lets the issue through: issue wins.
    assign w_same      = i_commit && (i_commit_addr == i_issue_addr);
    assign w_issue_acc = i_issue_en && (i_issue_addr != '0) && (!r_busy[i_issue_addr] || w_same);
    assign w_set       = w_issue_acc && !r_busy[i_issue_addr];
    assign w_clr       = i_commit && r_busy[i_commit_addr] && !(w_issue_acc && w_same);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (i_commit)
                r_busy[i_commit_addr] <= 1'b0;
            if (w_issue_acc)
                r_busy[i_issue_addr] <= 1'b1;
            case ({w_set, w_clr})
                2'b10:   r_pend_cnt <= r_pend_cnt + CNT_ONE;
                2'b01:   r_pend_cnt <= r_pend_cnt - CNT_ONE;
                default: r_pend_cnt <= r_pend_cnt;
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_issue_ready = !r_busy[i_issue_addr];
    assign o_pend_cnt    = r_pend_cnt;
endmodule

// File: rtl/reg_file_sb.sv
// 2R/1W register file (x0 = 0) with write-pending scoreboard; reads combinational, writes visible next cycle.
// Decode stalls on ISSUE_READY low; REGFILE_BYPASS_EN forwards a same-cycle commit to the read ports.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic          CLK,
    input  logic          RESETN,
    reg_file_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              r_armed;
    logic              w_commit;
    logic              w_issue_en;
    logic [DEPTH-1:0]  w_busy;
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic              w_rd_busy [2];

    // r_armed drops the first edge after reset release so a stale commit/issue cannot land.
    assign w_commit   = r_armed && bus.WR_EN && bus.WR_VALID && (bus.WR_ADDR != '0);
    assign w_issue_en = r_armed && bus.ISSUE_EN;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_armed <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_commit)
                r_regs[bus.WR_ADDR] <= bus.WR_DATA;
        end
    end

    reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk           (CLK),
        .rst_n         (RESETN),
        .i_commit      (w_commit),
        .i_commit_addr (bus.WR_ADDR),
        .i_issue_en    (w_issue_en),
        .i_issue_addr  (bus.ISSUE_ADDR),
        .o_busy        (w_busy),
        .o_issue_ready (bus.ISSUE_READY),
        .o_pend_cnt    (bus.PEND_CNT)
    );

    assign w_rd_addr[0] = bus.RD1_ADDR;
    assign w_rd_addr[1] = bus.RD2_ADDR;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_data[p] = r_regs[w_rd_addr[p]];
            w_rd_busy[p] = w_busy[w_rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (w_commit && (bus.WR_ADDR == w_rd_addr[p])) begin
                w_rd_data[p] = bus.WR_DATA;
                w_rd_busy[p] = 1'b0;
            end
`endif
            if (w_rd_addr[p] == '0) begin
                w_rd_data[p] = '0;
                w_rd_busy[p] = 1'b0;
            end
        end
    end

    assign bus.RD1_DATA = w_rd_data[0];
    assign bus.RD2_DATA = w_rd_data[1];
    assign bus.RD1_BUSY = w_rd_busy[0];
    assign bus.RD2_BUSY = w_rd_busy[1];
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed plus random stimulus against an array-based register/busy model.
`timescale 1ns/1ps
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int AW   = ADDR_W_DEF;
    localparam int DW   = DATA_W_DEF;
    localparam int NREG = 1 << AW;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK    (clk),
        .RESETN (rst_n),
        .bus    (bus)
    );

    reg_data_t m_regs [NREG];
    bit        m_busy [NREG];
    bit        m_skip;
    int        n_vec = 0;
    int        n_err = 0;

    function automatic int m_pend();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic bit m_commit();
        return rst_n && !m_skip && bus.WR_EN && bus.WR_VALID && (bus.WR_ADDR != ZERO_ADDR);
    endfunction

    function automatic reg_data_t m_rd(reg_addr_t a);
        if (a == ZERO_ADDR) return '0;
        if (BYP && m_commit() && bus.WR_ADDR == a) return bus.WR_DATA;
        return m_regs[a];
    endfunction

    function automatic bit m_rbusy(reg_addr_t a);
        if (a == ZERO_ADDR) return 1'b0;
        if (BYP && m_commit() && bus.WR_ADDR == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_skip = 1'b1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".rd1_data"}, 64'(bus.RD1_DATA), 64'(m_rd(bus.RD1_ADDR)));
        chk({tag, ".rd2_data"}, 64'(bus.RD2_DATA), 64'(m_rd(bus.RD2_ADDR)));
        chk({tag, ".rd1_busy"}, 64'(bus.RD1_BUSY), 64'(m_rbusy(bus.RD1_ADDR)));
        chk({tag, ".rd2_busy"}, 64'(bus.RD2_BUSY), 64'(m_rbusy(bus.RD2_ADDR)));
        chk({tag, ".ready"}, 64'(bus.ISSUE_READY),
            64'((bus.ISSUE_ADDR == ZERO_ADDR) || !m_busy[bus.ISSUE_ADDR]));
        chk({tag, ".pend"}, 64'(bus.PEND_CNT), 64'(m_pend()));
    endtask

    // Advance one rising edge, applying the spec rules to the model from pre-edge inputs.
    task automatic tick();
        bit        c, iss;
        reg_addr_t wa, ia;
        reg_data_t wd;
        c   = m_commit();
        wa  = bus.WR_ADDR;
        wd  = bus.WR_DATA;
        ia  = bus.ISSUE_ADDR;
        iss = rst_n && !m_skip && bus.ISSUE_EN && (ia != ZERO_ADDR) &&
              (!m_busy[ia] || (c && wa == ia));
        @(posedge clk);
        #1;
        if (c) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (iss) m_busy[ia] = 1'b1;
        if (rst_n) m_skip = 1'b0;
    endtask

    task automatic drive(bit we, bit wv, int wa, reg_data_t wd, bit ie, int ia, int r1, int r2);
        bus.WR_EN      = we;
        bus.WR_VALID   = wv;
        bus.WR_ADDR    = reg_addr_t'(wa);
        bus.WR_DATA    = wd;
        bus.ISSUE_EN   = ie;
        bus.ISSUE_ADDR = reg_addr_t'(ia);
        bus.RD1_ADDR   = reg_addr_t'(r1);
        bus.RD2_ADDR   = reg_addr_t'(r2);
        #1;
    endtask

    task automatic chk_all_addrs_zero(string tag);
        for (int i = 0; i < NREG; i++) begin
            bus.RD1_ADDR = reg_addr_t'(i);
            bus.RD2_ADDR = reg_addr_t'(NREG - 1 - i);
            #1;
            chk({tag, ".rd1"}, 64'(bus.RD1_DATA), 64'(0));
            chk({tag, ".rd2"}, 64'(bus.RD2_DATA), 64'(0));
            chk({tag, ".busy1"}, 64'(bus.RD1_BUSY), 64'(0));
        end
        chk({tag, ".pend"}, 64'(bus.PEND_CNT), 64'(0));
        chk({tag, ".ready"}, 64'(bus.ISSUE_READY), 64'(1));
    endtask

    initial begin
        m_clear();
        drive(0, 0, 0, '0, 0, 7, 0, 0);

        // Reset asserted mid-cycle at t=3, with a write to reg 2 held throughout.
        #2;
        rst_n = 1'b0;
        m_clear();
        #1;
        chk_all_addrs_zero("reset");
        drive(1, 1, 2, 95, 0, 7, 2, 0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(0, 0, 0, '0, 0, 0, 2, 0);
        chk("reset_wr_dropped", 64'(bus.RD1_DATA), 64'(0));
        chk_all("post_reset");

        // Basic commit, invalid commit, commit to x0.
        drive(1, 1, 1, 28, 0, 0, 1, 0);
        chk_all("commit28_pre");
        tick();
        drive(0, 0, 0, '0, 0, 0, 1, 0);
        chk("commit28", 64'(bus.RD1_DATA), 64'(28));
        drive(1, 0, 1, 77, 0, 0, 1, 0);
        tick();
        chk("commit_invalid", 64'(bus.RD1_DATA), 64'(28));
        drive(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        tick();
        chk("commit_x0", 64'(bus.RD1_DATA), 64'(0));
        chk_all("x0");

        // Issue, WAW rejection, commit clears busy.
        drive(0, 0, 0, '0, 1, 5, 5, 0);
        tick();
        chk("issue5_busy", 64'(bus.RD1_BUSY), 64'(1));
        chk("issue5_pend", 64'(bus.PEND_CNT), 64'(1));
        chk("reissue5_ready", 64'(bus.ISSUE_READY), 64'(0));
        tick();
        chk("reissue5_pend", 64'(bus.PEND_CNT), 64'(1));
        drive(1, 1, 5, 6, 0, 0, 5, 0);
        tick();
        drive(0, 0, 0, '0, 0, 0, 5, 0);
        chk("commit5_busy", 64'(bus.RD1_BUSY), 64'(0));
        chk("commit5_pend", 64'(bus.PEND_CNT), 64'(0));
        chk("commit5_data", 64'(bus.RD1_DATA), 64'(6));

        // Same-edge commit and issue on a busy register: issue wins.
        drive(0, 0, 0, '0, 1, 4, 4, 0);
        tick();
        drive(1, 1, 4, 15, 1, 4, 4, 0);
        tick();
        drive(0, 0, 0, '0, 0, 0, 4, 0);
        chk("same_edge_data", 64'(bus.RD1_DATA), 64'(15));
        chk("same_edge_busy", 64'(bus.RD1_BUSY), 64'(1));
        chk("same_edge_pend", 64'(bus.PEND_CNT), 64'(1));
        drive(1, 1, 4, 16, 0, 0, 4, 0);
        tick();
        chk_all("clear4");

        // Fill every register, then drain with extra commits past empty.
        for (int i = 1; i < NREG; i++) begin
            drive(0, 0, 0, '0, 1, i, i, 0);
            tick();
        end
        drive(0, 0, 0, '0, 0, 0, 0, 0);
        chk("fill_pend", 64'(bus.PEND_CNT), 64'(NREG - 1));
        for (int i = 1; i < NREG; i++) begin
            drive(1, 1, i, reg_data_t'(i * 3), 0, 0, i, 0);
            tick();
        end
        drive(0, 0, 0, '0, 0, 0, 0, 0);
        chk("drain_pend", 64'(bus.PEND_CNT), 64'(0));
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 7 + i, reg_data_t'(100 + i), 0, 0, 7 + i, 0);
            tick();
        end
        chk("underflow_pend", 64'(bus.PEND_CNT), 64'(0));

        // Same-cycle read of a committing register (reg 1 currently holds 3).
        drive(1, 1, 1, 50, 0, 0, 0, 1);
        chk("bypass_same_cycle", 64'(bus.RD2_DATA), BYP ? 64'(50) : 64'(3));
        chk("bypass_busy", 64'(bus.RD2_BUSY), 64'(0));
        tick();
        drive(0, 0, 0, '0, 0, 0, 0, 1);
        chk("bypass_next_cycle", 64'(bus.RD2_DATA), 64'(50));

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            drive(bit'($urandom_range(1, 0)), bit'($urandom_range(3, 0) != 0),
                  int'($urandom_range(NREG - 1, 0)), reg_data_t'($urandom()),
                  bit'($urandom_range(1, 0)), int'($urandom_range(NREG - 1, 0)),
                  int'($urandom_range(NREG - 1, 0)), int'($urandom_range(NREG - 1, 0)));
            chk_all("rand");
            tick();
        end
        drive(0, 0, 0, '0, 0, 0, 0, 0);
        chk_all("rand_end");

        // Asynchronous reset mid-cycle while a commit and issue are in flight.
        drive(1, 1, 9, 32'hDEAD_BEEF, 1, 10, 9, 10);
        #2;
        rst_n = 1'b0;
        m_clear();
        #1;
        chk_all_addrs_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, '0, 0, 0, 9, 10);
        tick();
        chk_all("after_midreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with a write-pending scoreboard for the pipelined RISC-V core, sitting between the decode stage (reads and destination issue) and writeback (commit). It provides two combinational read ports and one clocked write port, with register 0 hardwired to zero. A per-register busy bit and a pending counter let decode detect RAW and WAW hazards without external tracking. Optional write-to-read bypass removes the one-cycle writeback bubble.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESETN  in  1  asynchronous, active-low reset
- RD1_ADDR, RD2_ADDR  in  ADDR_W  read addresses
- RD1_DATA, RD2_DATA  out  DATA_W  read data (combinational)
- RD1_BUSY, RD2_BUSY  out  1  addressed register has a pending write
- WR_EN  in  1  write enable
- WR_VALID  in  1  instruction valid qualifier; a write commits only when WR_EN && WR_VALID
- WR_ADDR  in  ADDR_W  write address
- WR_DATA  in  DATA_W  write data
- ISSUE_EN  in  1  decode requests marking ISSUE_ADDR as pending
- ISSUE_ADDR  in  ADDR_W  destination register being issued
- ISSUE_READY  out  1  issue can be accepted this cycle
- PEND_CNT  out  ADDR_W+1  number of registers currently busy

## Operation
- Commit: WR_EN && WR_VALID && WR_ADDR != 0. At the rising edge, regs[WR_ADDR] <= WR_DATA and busy[WR_ADDR] <= 0.
- Commit to a non-busy register is legal. It updates data, leaves busy unchanged, and leaves PEND_CNT unchanged.
- Writes to address 0 are discarded. Reads of address 0 return 0 and busy 0.
- Issue accepted = ISSUE_EN && ISSUE_READY && ISSUE_ADDR != 0. This sets busy[ISSUE_ADDR] <= 1.
- ISSUE_READY = !busy[ISSUE_ADDR] from registered state. A WAW to a busy register is rejected and decode stalls. ISSUE_EN with ISSUE_ADDR = 0 is always ready and has no effect.
- Same-edge commit and accepted issue to the same address: data is written and busy ends at 1 (issue wins). PEND_CNT is unchanged in this case.
- PEND_CNT: +1 for each accepted issue that sets a clear bit, −1 for each commit that clears a set bit, net 0 when both happen. It always equals popcount(busy) and never exceeds 2**ADDR_W−1.
- RDx_BUSY = busy[RDx_ADDR], subject to the bypass override below.

## Timing
- Reads are combinational, with zero added latency.
- Writes are visible on the read ports from the cycle after the commit edge (without bypass).
- Issue-to-busy latency is 1 edge. Busy clears on the commit edge.
- RESETN low, asynchronously and at any time including mid-write: all regs = 0, all busy = 0, PEND_CNT = 0.
  - Resulting outputs: RDx_DATA = 0, RDx_BUSY = 0, ISSUE_READY = 1.
- A commit or issue coinciding with the edge on which RESETN deasserts is ignored.
- No # delays in RTL.

## Configuration
- REGFILE_BYPASS_EN defined: when a commit targets RDx_ADDR (nonzero) in the current cycle:
  - RDx_DATA = WR_DATA and RDx_BUSY = 0, combinationally, the same cycle.
  - An issue in the same cycle does not affect the read ports until the next cycle.
- REGFILE_BYPASS_EN undefined: read ports show registered contents and busy only, so there is a one-cycle bubble after commit.

## Structure
- Package reg_file_pkg holds:
  - DATA_W and ADDR_W defaults
  - ZERO_ADDR constant
  - typedef reg_addr_t (logic [ADDR_W-1:0])
  - typedef reg_data_t (logic [DATA_W-1:0])
- Sub-module reg_scoreboard contains:
  - the busy vector
  - the PEND_CNT counter
  - issue/commit arbitration
  - ISSUE_READY generation
- reg_file_sb holds the storage array, read muxes and the bypass.

## Test plan
- Reset then read: RESETN=0 at t=3 (mid-cycle), all addresses read 0, PEND_CNT=0, ISSUE_READY=1. Also write 95 to reg 2 during reset → read 0 after release.
- Commit 28 to reg 1 with WR_VALID=1 → RD1_DATA=28 next cycle. Same commit with WR_VALID=0 → reg 1 unchanged. Commit 0xFFFF_FFFF to reg 0 → reads 0.
- Issue reg 5 → RD1_BUSY=1 and PEND_CNT=1. Re-issue reg 5 → ISSUE_READY=0, PEND_CNT stays 1. Commit 6 to reg 5 → busy 0, PEND_CNT=0, data 6.
- Same-edge commit 15 and issue to reg 4 (reg 4 busy) → data 15, busy stays 1, PEND_CNT unchanged.
- Issue all 31 nonzero registers → PEND_CNT=31. Commit all 31 → PEND_CNT=0, with no underflow on extra commits.
- Bypass (with REGFILE_BYPASS_EN): commit 50 to reg 1 while RD2_ADDR=1 → RD2_DATA=50 and RD2_BUSY=0 in the same cycle. Without the macro → old value, then 50 next cycle.
